// File: rtl/melody_sequencer.sv
// Melody sequencer: walks a synchronous melody ROM and drives the square-wave tone generator
// with a half-period divider, tone enable and per-entry start strobe, timed in tempo ticks.
module melody_sequencer #(
  parameter int ADDR_W      = 6,
  parameter int TICK_CYCLES = 6_250_000,
  parameter int GAP_CYCLES  = 1_000_000
) (
  input  logic              CLK100MHZ,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [8:0]        rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [17:0]       tone_div,
  output logic              tone_en,
  output logic              note_strobe,
  output logic              busy
);

  localparam int PLAY_MAX = 7 * TICK_CYCLES;
  localparam int CNT_MAX  = (PLAY_MAX > GAP_CYCLES) ? PLAY_MAX : GAP_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TICK_C  = CNT_W'(TICK_CYCLES);
  localparam logic [CNT_W-1:0] GAP_C   = CNT_W'(GAP_CYCLES);
  localparam logic             HAS_GAP = (GAP_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_PLAY   = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  // Half-period dividers for A3..G#4 at 100 MHz; higher octaves are right shifts.
  function automatic logic [17:0] base_div(input logic [3:0] semi);
    case (semi)
      4'd0:    base_div = 18'd227273;
      4'd1:    base_div = 18'd214519;
      4'd2:    base_div = 18'd202478;
      4'd3:    base_div = 18'd191113;
      4'd4:    base_div = 18'd180388;
      4'd5:    base_div = 18'd170265;
      4'd6:    base_div = 18'd160705;
      4'd7:    base_div = 18'd151685;
      4'd8:    base_div = 18'd143172;
      4'd9:    base_div = 18'd135139;
      4'd10:   base_div = 18'd127551;
      4'd11:   base_div = 18'd120395;
      default: base_div = 18'd0;
    endcase
  endfunction

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [17:0]         r_div, w_div_nxt;
  logic                r_en, w_en_nxt;
  logic                r_strobe, w_strobe_nxt;
  logic                r_busy;

  logic [2:0]          w_len;
  logic [1:0]          w_oct;
  logic [3:0]          w_semi;
  logic                w_rest;

  assign w_len  = rom_data[8:6];
  assign w_oct  = rom_data[5:4];
  assign w_semi = rom_data[3:0];
  assign w_rest = w_semi[3] & w_semi[2];

  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_div    <= 18'd0;
      r_en     <= 1'b0;
      r_strobe <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_addr   <= w_addr_nxt;
      r_div    <= w_div_nxt;
      r_en     <= w_en_nxt;
      r_strobe <= w_strobe_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_addr_nxt   = r_addr;
    w_div_nxt    = r_div;
    w_en_nxt     = r_en;
    w_strobe_nxt = 1'b0;
    // stop overrides everything and discards whatever note was in progress
    if (stop) begin
      w_state_nxt = S_IDLE;
      w_addr_nxt  = '0;
      w_en_nxt    = 1'b0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_nxt = S_FETCH;
            w_addr_nxt  = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_FETCH: w_state_nxt = S_DECODE;
        S_DECODE: begin
          if (w_len == 3'd0) begin
            w_state_nxt = loop ? S_FETCH : S_IDLE;
            w_addr_nxt  = '0;
          end else begin
            w_state_nxt  = S_PLAY;
            w_div_nxt    = base_div(w_semi) >> w_oct;
            w_en_nxt     = ~w_rest;
            w_strobe_nxt = 1'b1;
            w_cnt_nxt    = CNT_W'(w_len) * TICK_C;
          end
        end
        S_PLAY: begin
          if (r_cnt <= CNT_W'(1)) begin
            w_en_nxt = 1'b0;
            if (HAS_GAP) begin
              w_state_nxt = S_GAP;
              w_cnt_nxt   = GAP_C;
            end else begin
              w_state_nxt = S_FETCH;
              w_addr_nxt  = r_addr + ADDR_W'(1);
              w_cnt_nxt   = '0;
            end
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        S_GAP: begin
          if (r_cnt <= CNT_W'(1)) begin
            w_state_nxt = S_FETCH;
            w_addr_nxt  = r_addr + ADDR_W'(1);
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_addr_nxt  = '0;
          w_en_nxt    = 1'b0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign rom_addr    = r_addr;
  assign tone_div    = r_div;
  assign tone_en     = r_en;
  assign note_strobe = r_strobe;
  assign busy        = r_busy;

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer with a small behavioural synchronous ROM.
module tb_melody_sequencer;

  logic        CLK100MHZ = 1'b0;
  logic        rst, start, stop, loop;
  logic [8:0]  rom_data;
  logic [2:0]  rom_addr;
  logic [17:0] tone_div;
  logic        tone_en, note_strobe, busy;
  logic [8:0]  mem [0:7];

  int n_tests = 0;
  int n_fail  = 0;

  melody_sequencer #(.ADDR_W(3), .TICK_CYCLES(10), .GAP_CYCLES(2)) dut (
    .CLK100MHZ(CLK100MHZ), .rst(rst), .start(start), .stop(stop), .loop(loop),
    .rom_addr(rom_addr), .rom_data(rom_data), .tone_div(tone_div),
    .tone_en(tone_en), .note_strobe(note_strobe), .busy(busy)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  always @(posedge CLK100MHZ) rom_data <= mem[rom_addr];

  typedef struct {
    logic [8:0]  w0;
    logic [8:0]  w1;
    logic [17:0] exp_div;
    int          exp_en;
    int          exp_strobes;
    int          exp_busy;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 8; i++) mem[i] = 9'd0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int busy_cnt, en_cnt, strobes, first_at, k;
    logic [17:0] last_div;
    clear_mem();
    mem[0] = v.w0;
    mem[1] = v.w1;
    loop  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check($sformatf("v%0d_addr0", idx), rom_addr, 0);
    busy_cnt = busy ? 1 : 0;
    en_cnt = 0; strobes = 0; first_at = -1; last_div = 18'd0;
    for (k = 1; k < 300; k++) begin
      tick();
      if (busy) busy_cnt++;
      if (tone_en) en_cnt++;
      if (note_strobe) begin
        strobes++;
        if (first_at < 0) first_at = k;
        last_div = tone_div;
      end
      if (!busy) break;
    end
    check($sformatf("v%0d_timeout", idx), (k < 300) ? 1 : 0, 1);
    check($sformatf("v%0d_strobe_lat", idx), first_at, 2);
    check($sformatf("v%0d_div", idx), last_div, v.exp_div);
    check($sformatf("v%0d_en_cycles", idx), en_cnt, v.exp_en);
    check($sformatf("v%0d_strobes", idx), strobes, v.exp_strobes);
    check($sformatf("v%0d_busy_cycles", idx), busy_cnt, v.exp_busy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_str, max_addr, k;
    logic busy_low, en_seen;
    int saddr [10];

    vecs[0] = '{9'b001_00_0000, 9'd0,         18'd227273, 10, 1, 16};
    vecs[1] = '{9'b010_11_0011, 9'd0,         18'd23889,  20, 1, 26};
    vecs[2] = '{9'b001_01_1001, 9'd0,         18'd67569,  10, 1, 16};
    vecs[3] = '{9'b111_10_1011, 9'd0,         18'd30098,  70, 1, 76};
    vecs[4] = '{9'b011_00_1100, 9'b001_00_0000, 18'd227273, 10, 2, 50};
    vecs[5] = '{9'b011_00_0110, 9'd0,         18'd160705, 30, 1, 36};

    rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
    clear_mem();
    repeat (3) @(posedge CLK100MHZ);
    #1;
    check("rst_addr", rom_addr, 0);
    check("rst_div", tone_div, 0);
    check("rst_en", tone_en, 0);
    check("rst_strobe", note_strobe, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // looped playback of two notes plus end marker
    clear_mem();
    mem[0] = 9'b001_00_0000;
    mem[1] = 9'b001_00_0001;
    loop = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    n_str = 0; max_addr = 0; busy_low = 1'b0;
    for (k = 0; k < 130; k++) begin
      tick();
      if (!busy) busy_low = 1'b1;
      if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
      if (note_strobe && n_str < 10) begin
        saddr[n_str] = int'(rom_addr);
        n_str++;
      end
    end
    check("loop_nstrobes_ge4", (n_str >= 4) ? 1 : 0, 1);
    check("loop_addr_s0", saddr[0], 0);
    check("loop_addr_s1", saddr[1], 1);
    check("loop_addr_s2", saddr[2], 0);
    check("loop_addr_s3", saddr[3], 1);
    check("loop_max_addr", max_addr, 2);
    check("loop_busy_held", busy_low, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("loop_stop_busy", busy, 0);
    check("loop_stop_en", tone_en, 0);
    check("loop_stop_addr", rom_addr, 0);
    repeat (3) tick();
    check("loop_stop_stays_idle", busy, 0);

    // end marker at entry 0 with loop: spins FETCH/DECODE silently
    clear_mem();
    loop = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    busy_low = 1'b0; en_seen = 1'b0;
    for (k = 0; k < 20; k++) begin
      tick();
      if (!busy) busy_low = 1'b1;
      if (tone_en || note_strobe) en_seen = 1'b1;
    end
    check("empty_loop_busy", busy_low, 0);
    check("empty_loop_silent", en_seen, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    loop = 1'b0;
    check("empty_loop_stop_busy", busy, 0);

    // stop mid-PLAY, then start and stop together in IDLE
    clear_mem();
    mem[0] = 9'b011_00_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    check("midplay_en", tone_en, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_en", tone_en, 0);
    check("stop_addr", rom_addr, 0);
    start = 1'b1; stop = 1'b1;
    tick();
    check("startstop_busy", busy, 0);
    check("startstop_en", tone_en, 0);
    start = 1'b0; stop = 1'b0;
    tick();
    check("startstop_idle", busy, 0);

    // eight notes, no end marker: address wraps 7 -> 0
    for (int i = 0; i < 8; i++) mem[i] = 9'b001_00_0000 | 9'(i);
    loop = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    n_str = 0;
    for (k = 0; k < 250 && n_str < 9; k++) begin
      tick();
      if (note_strobe) begin
        saddr[n_str] = int'(rom_addr);
        n_str++;
      end
    end
    check("wrap_nstrobes", n_str, 9);
    check("wrap_addr7", saddr[7], 7);
    check("wrap_addr8", saddr[8], 0);
    check("wrap_div", tone_div, 227273);
    repeat (3) tick();
    check("wrap_midplay_en", tone_en, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_addr", rom_addr, 0);
    check("async_rst_div", tone_div, 0);
    check("async_rst_en", tone_en, 0);
    check("async_rst_strobe", note_strobe, 0);
    check("async_rst_busy", busy, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("post_rst_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
